// File: rtl/rsa_modexp_unit.sv
// Modular exponentiation (left-to-right square-and-multiply, bit-serial modmul).
// Optional macro RSA_SKIP_LEADING_ZEROS_EN: start the exponent scan at its highest set bit.
//
// state | meaning
// IDLE  | waiting for en_rsa & rst_rsa
// LOAD  | latch operands, check them, pick first exponent bit
// SQR   | acc = acc*acc mod n, WIDTH cycles
// MUL   | acc = acc*m mod n, WIDTH cycles
// DONE  | publish cipher, eoc_rsa_unit high for one cycle
// HOLD  | parked until the sequencer drops en_rsa or rst_rsa
module rsa_modexp_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_rsa,
   input  logic             rst_rsa,
   input  logic [WIDTH-1:0] plain,
   input  logic [WIDTH-1:0] exponent,
   input  logic [WIDTH-1:0] modulus,
   output logic [WIDTH-1:0] cipher,
   output logic             eoc_rsa_unit,
   output logic             busy,
   output logic             err
);

   localparam int IW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      SQR  = 3'd2,
      MUL  = 3'd3,
      DONE = 3'd4,
      HOLD = 3'd5
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [WIDTH-1:0] r_m;
   logic [WIDTH-1:0] r_e;
   logic [WIDTH-1:0] r_n;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH+1:0] r_p;
   logic [IW-1:0]    r_bcnt;
   logic [IW-1:0]    r_idx;
   logic [WIDTH-1:0] r_cipher;
   logic             r_err;

   logic             w_bad;
   logic             w_op_done;
   logic [IW-1:0]    w_idx_start;
   logic [WIDTH+1:0] w_n_ext;
   logic [WIDTH+1:0] w_y_ext;
   logic [WIDTH+1:0] w_p_dbl;
   logic [WIDTH+1:0] w_p_r1;
   logic [WIDTH+1:0] w_p_add;
   logic [WIDTH+1:0] w_p_nxt;

   assign w_bad     = (modulus < WIDTH'(2)) || (plain >= modulus);
   assign w_op_done = (r_bcnt == '0);

   always_comb begin
      w_idx_start = IW'(WIDTH - 1);
`ifdef RSA_SKIP_LEADING_ZEROS_EN
      w_idx_start = '0;
      for (int k = 0; k < WIDTH; k++) begin
         if (exponent[k]) w_idx_start = IW'(k);
      end
`endif
   end

   // One interleaved step: P = 2P + x[j]*y, reduced twice so P stays below n.
   assign w_n_ext = {2'b00, r_n};
   assign w_y_ext = (r_state == MUL) ? {2'b00, r_m} : {2'b00, r_acc};
   assign w_p_dbl = r_p << 1;
   assign w_p_r1  = (w_p_dbl >= w_n_ext) ? (w_p_dbl - w_n_ext) : w_p_dbl;
   assign w_p_add = r_acc[r_bcnt] ? (w_p_r1 + w_y_ext) : w_p_r1;
   assign w_p_nxt = (w_p_add >= w_n_ext) ? (w_p_add - w_n_ext) : w_p_add;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      eoc_rsa_unit = (r_state == DONE);
      busy         = (r_state == LOAD) || (r_state == SQR) || (r_state == MUL);
      if (!rst_rsa) begin
         w_state_nxt = IDLE;
      end else if (!en_rsa) begin
         // HOLD is the only state that reacts to a dropped enable
         if (r_state == HOLD) w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: w_state_nxt = LOAD;
            LOAD: w_state_nxt = (w_bad || exponent == '0) ? DONE : SQR;
            SQR: begin
               if (w_op_done) begin
                  if (r_e[r_idx])          w_state_nxt = MUL;
                  else if (r_idx == '0)    w_state_nxt = DONE;
                  else                     w_state_nxt = SQR;
               end
            end
            MUL: begin
               if (w_op_done) w_state_nxt = (r_idx == '0) ? DONE : SQR;
            end
            DONE:    w_state_nxt = HOLD;
            HOLD:    w_state_nxt = HOLD;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_m      <= '0;
         r_e      <= '0;
         r_n      <= '0;
         r_acc    <= '0;
         r_p      <= '0;
         r_bcnt   <= '0;
         r_idx    <= '0;
         r_cipher <= '0;
         r_err    <= 1'b0;
      end else if (!rst_rsa) begin
         r_cipher <= '0;
         r_err    <= 1'b0;
      end else if (en_rsa) begin
         case (r_state)
            LOAD: begin
               r_m      <= plain;
               r_e      <= exponent;
               r_n      <= modulus;
               r_acc    <= WIDTH'(1);
               r_p      <= '0;
               r_bcnt   <= IW'(WIDTH - 1);
               r_idx    <= w_idx_start;
               r_err    <= w_bad;
               r_cipher <= (!w_bad && exponent == '0) ? WIDTH'(1) : '0;
            end
            SQR, MUL: begin
               if (w_op_done) begin
                  r_acc  <= w_p_nxt[WIDTH-1:0];
                  r_p    <= '0;
                  r_bcnt <= IW'(WIDTH - 1);
                  if (w_state_nxt == SQR)  r_idx    <= r_idx - 1'b1;
                  if (w_state_nxt == DONE) r_cipher <= w_p_nxt[WIDTH-1:0];
               end else begin
                  r_p    <= w_p_nxt;
                  r_bcnt <= r_bcnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign cipher = r_cipher;
   assign err    = r_err;

endmodule

// File: tb/tb_rsa_modexp_unit.sv
// Bench for rsa_modexp_unit: directed and random runs against a plain-arithmetic model.
module tb_rsa_modexp_unit;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         en_rsa;
   logic         rst_rsa;
   logic [W-1:0] plain;
   logic [W-1:0] exponent;
   logic [W-1:0] modulus;
   logic [W-1:0] cipher;
   logic         eoc_rsa_unit;
   logic         busy;
   logic         err;

   int n_cmp = 0;
   int n_bad = 0;

   rsa_modexp_unit #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .en_rsa       (en_rsa),
      .rst_rsa      (rst_rsa),
      .plain        (plain),
      .exponent     (exponent),
      .modulus      (modulus),
      .cipher       (cipher),
      .eoc_rsa_unit (eoc_rsa_unit),
      .busy         (busy),
      .err          (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   // Result by repeated multiplication; latency from the squared-bit count and popcount.
   function automatic void model(input int m, input int e, input int n,
                                 output int c, output bit er, output int l);
      longint acc;
      int s;
      int pop;
      er = (n < 2) || (m >= n);
      c  = 0;
      l  = 1;
      if (er) return;
      acc = 1;
      repeat (e) acc = (acc * m) % n;
      c = int'(acc);
      if (e == 0) return;
      pop = 0;
      s   = 0;
      for (int k = 0; k < W; k++) begin
         if (((e >> k) & 1) == 1) begin
            pop++;
            s = k + 1;
         end
      end
`ifndef RSA_SKIP_LEADING_ZEROS_EN
      s = W;
`endif
      l = 1 + W * (s + pop);
   endfunction

   task automatic run_case(input int m, input int e, input int n,
                           input int frz_at, input int frz_len,
                           input int abort_at, input int rst_at, input bit hold_rst);
      int exp_c, exp_l, lat;
      bit exp_err, run_ok, frz_ok, seen;
      model(m, e, n, exp_c, exp_err, exp_l);
      if (frz_at >= 0) exp_l += frz_len;
      @(negedge clk);
      plain = W'(m); exponent = W'(e); modulus = W'(n);
      en_rsa = 1'b1; rst_rsa = 1'b1;
      @(posedge clk);
      lat = 0; run_ok = 1'b1; frz_ok = 1'b1; seen = 1'b0;
      while (!seen && lat < exp_l + 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         plain = W'($urandom); exponent = W'($urandom); modulus = W'($urandom);
         if (eoc_rsa_unit) begin
            seen = 1'b1;
         end else begin
            if (!busy || cipher != 0 || err) run_ok = 1'b0;
            if (lat == abort_at || lat == rst_at) begin
               if (lat == abort_at) rst_rsa = 1'b0;
               else                 rst = 1'b1;
               @(posedge clk);
               @(negedge clk);
               chk("clr_busy", busy, 0);
               chk("clr_eoc", eoc_rsa_unit, 0);
               chk("clr_cipher", cipher, 0);
               chk("clr_err", err, 0);
               rst = 1'b0; rst_rsa = 1'b1; en_rsa = 1'b0;
               return;
            end
            if (lat == frz_at) begin
               en_rsa = 1'b0;
               repeat (frz_len) begin
                  @(posedge clk);
                  lat++;
                  @(negedge clk);
                  if (eoc_rsa_unit || !busy || cipher != 0) frz_ok = 1'b0;
               end
               en_rsa = 1'b1;
            end
         end
      end
      chk("eoc_seen", seen, 1);
      if (!seen) begin
         rst = 1'b1; en_rsa = 1'b0;
         @(posedge clk);
         @(negedge clk);
         rst = 1'b0;
         return;
      end
      chk("latency", lat, exp_l);
      chk("cipher", cipher, exp_c);
      chk("err", err, exp_err);
      chk("busy_run", run_ok, 1);
      if (frz_at >= 0) chk("frozen", frz_ok, 1);
      @(posedge clk);
      @(negedge clk);
      chk("eoc_one_cycle", eoc_rsa_unit, 0);
      chk("hold_busy", busy, 0);
      chk("hold_cipher", cipher, exp_c);
      if (hold_rst) begin
         rst = 1'b1;
         @(posedge clk);
         @(negedge clk);
         chk("hrst_cipher", cipher, 0);
         chk("hrst_err", err, 0);
         chk("hrst_eoc", eoc_rsa_unit, 0);
         rst = 1'b0; en_rsa = 1'b0;
      end else begin
         en_rsa = 1'b0;
         @(posedge clk);
         @(negedge clk);
         chk("idle_cipher", cipher, exp_c);
         chk("idle_eoc", eoc_rsa_unit, 0);
      end
   endtask

   initial begin
      int n, m, e, fa, c0, l0;
      bit e0;
      rst = 1'b1; en_rsa = 1'b0; rst_rsa = 1'b1;
      plain = '0; exponent = '0; modulus = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cipher", cipher, 0);
      chk("rst_eoc", eoc_rsa_unit, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;

      run_case(5, 3, 33, -1, 0, -1, -1, 1'b0);
      run_case(7, 13, 187, -1, 0, -1, -1, 1'b0);
      run_case(9, 0, 20, -1, 0, -1, -1, 1'b0);
      run_case(40, 3, 33, -1, 0, -1, -1, 1'b0);
      run_case(0, 5, 1, -1, 0, -1, -1, 1'b0);
      run_case(5, 3, 33, 5, 10, -1, -1, 1'b0);
      run_case(7, 13, 187, -1, 0, 20, -1, 1'b0);
      run_case(7, 13, 187, -1, 0, -1, -1, 1'b0);
      run_case(7, 13, 187, -1, 0, -1, 30, 1'b0);
      run_case(5, 3, 33, -1, 0, -1, -1, 1'b1);
      run_case(255, 255, 254, -1, 0, -1, -1, 1'b0);
      run_case(253, 255, 254, -1, 0, -1, -1, 1'b0);

      for (int t = 0; t < 25; t++) begin
         n = int'($urandom_range(0, 255));
         if (n > 1 && $urandom_range(0, 7) != 0) m = int'($urandom_range(0, n - 1));
         else                                    m = int'($urandom_range(0, 255));
         e = int'($urandom_range(0, 255));
         model(m, e, n, c0, e0, l0);
         fa = (l0 > 2 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, l0 - 1)) : -1;
         run_case(m, e, n, fa, int'($urandom_range(1, 6)), -1, -1, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
